// File: rtl/comm_cmd_sched_if.sv
// Link bundle between the command scheduler, its requesters and the UART command transmitter.
// The scheduler takes the slave view; the environment (requesters plus transmitter) takes the master view.
interface comm_cmd_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] cmd_in;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [7:0]        command;
    logic              str;
    logic              ready_command;

    modport slave (
        input  req, cmd_in, ready_command,
        output gnt, done, command, str
    );

    modport master (
        output req, cmd_in, ready_command,
        input  gnt, done, command, str
    );
endinterface

// File: rtl/comm_cmd_sched.sv
// Round-robin scheduler sharing one command/str/ready_command link between NREQ requesters,
// with a fixed start strobe, an inter-command gap and a watchdog on link acceptance/completion.
module comm_cmd_sched #(
    parameter int NREQ       = 4,
    parameter int STR_CYCLES = 5,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 131072
) (
    input  logic            clk,
    input  logic            rst,
    comm_cmd_sched_if.slave bus,
    output logic            busy,
    output logic            timeout_err,
    input  logic            clr_err
);
    localparam int PW = $clog2(NREQ);
    localparam int SW = $clog2(STR_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [SW-1:0] STR_LAST = SW'(STR_CYCLES);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PTR_INIT = PW'(NREQ - 1);

    typedef enum logic [2:0] {IDLE, STROBE, WAIT_ACK, WAIT_DONE, GAP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [7:0]      command_q, command_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            str_q, str_d;
    logic            err_q, err_d;
    logic [SW-1:0]   str_cnt_q, str_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;

    logic            hi_valid, win_valid;
    logic [PW-1:0]   hi_idx, lo_idx, win_idx;
    logic [7:0]      win_cmd;

    // Lowest requester above the pointer wins; if none, wrap to the lowest requester overall.
    always_comb begin
        hi_valid  = 1'b0;
        win_valid = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i] && (PW'(i) > ptr_q)) begin
                hi_valid = 1'b1;
                hi_idx   = PW'(i);
            end
            if (bus.req[i]) begin
                win_valid = 1'b1;
                lo_idx    = PW'(i);
            end
        end
        win_idx = hi_valid ? hi_idx : lo_idx;
    end

    always_comb begin
        win_cmd = 8'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == PW'(i)) win_cmd = bus.cmd_in[8*i +: 8];
        end
    end

    // NOTE: every output of this block gets a default before the case; a path that skips
    // an assignment would otherwise make synthesis infer a latch to hold the old value.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        command_d = command_q;
        gnt_d     = '0;
        done_d    = '0;
        str_d     = 1'b0;
        str_cnt_d = str_cnt_q;
        gap_cnt_d = gap_cnt_q;
        to_cnt_d  = to_cnt_q;
        err_d     = err_q && !clr_err;

        case (state_q)
            IDLE: begin
                if (bus.ready_command && win_valid) begin
                    owner_d        = win_idx;
                    ptr_d          = win_idx;
                    command_d      = win_cmd;
                    gnt_d[win_idx] = 1'b1;
                    str_cnt_d      = '0;
                    state_d        = STROBE;
                end
            end
            STROBE: begin
                if (str_cnt_q == STR_LAST) begin
                    to_cnt_d = '0;
                    state_d  = WAIT_ACK;
                end else begin
                    str_d     = 1'b1;
                    str_cnt_d = str_cnt_q + 1'b1;
                end
            end
            WAIT_ACK: begin
                if (!bus.ready_command) begin
                    state_d = WAIT_DONE;
                    if (to_cnt_q != TO_LAST) to_cnt_d = to_cnt_q + 1'b1;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d     = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (bus.ready_command) begin
                    done_d[owner_q] = 1'b1;
                    gap_cnt_d       = '0;
                    state_d         = GAP;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d     = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = IDLE;
                else gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order within the block.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= PTR_INIT;
            owner_q   <= '0;
            command_q <= 8'd0;
            gnt_q     <= '0;
            done_q    <= '0;
            str_q     <= 1'b0;
            err_q     <= 1'b0;
            str_cnt_q <= '0;
            gap_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            command_q <= command_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            str_q     <= str_d;
            err_q     <= err_d;
            str_cnt_q <= str_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.str     = str_q;
    assign bus.command = command_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = err_q;
endmodule

// File: tb/tb_comm_cmd_sched.sv
// Bench for comm_cmd_sched: arbitration vector table, multi-cycle corner sequences,
// and random traffic against a transaction-level round-robin model.
module tb_comm_cmd_sched;
    localparam int NREQ       = 4;
    localparam int STR_CYCLES = 5;
    localparam int GAP_CYCLES = 16;
    localparam int TIMEOUT    = 200;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic timeout_err;
    logic clr_err;

    comm_cmd_sched_if #(.NREQ(NREQ)) bus ();

    comm_cmd_sched #(
        .NREQ(NREQ), .STR_CYCLES(STR_CYCLES), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .timeout_err(timeout_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int stray_gnt = 0;
    int stray_done = 0;

    typedef struct {
        logic [NREQ-1:0] req;
        logic [7:0]      base;
        int              exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickm();
        tick();
        if (bus.gnt != 0) stray_gnt++;
        if (bus.done != 0) stray_done++;
    endtask

    function automatic logic [31:0] onehot(input int i);
        return 32'(1) << i;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        int c;
        for (int k = 1; k <= NREQ; k++) begin
            c = (p + k) % NREQ;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_cmds(input logic [7:0] base);
        for (int i = 0; i < NREQ; i++) bus.cmd_in[8*i +: 8] = base + 8'(i);
    endtask

    task automatic wait_gnt(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (bus.gnt == 0 && lat < 300);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.req = '0;
        bus.ready_command = 1'b1;
        clr_err = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Starts at the sample where gnt is visible; plays the transmitter and checks the whole transfer.
    task automatic run_link(input string tag, input int owner, input int ack_dly, input int busy_len,
                            input logic [NREQ-1:0] blip);
        int n;
        n = 0;
        stray_gnt = 0;
        stray_done = 0;
        check({tag, " str low in gnt cycle"}, 32'(bus.str), 32'(0));
        tickm();
        while (bus.str && n < 4*STR_CYCLES) begin
            n++;
            if (n == 1) bus.req = bus.req | blip;
            if (n == 3) bus.req = bus.req & ~blip;
            tickm();
        end
        check({tag, " str width"}, n, STR_CYCLES);
        repeat (ack_dly) tickm();
        bus.ready_command = 1'b0;
        repeat (busy_len) tickm();
        bus.ready_command = 1'b1;
        tick();
        check({tag, " done pulse"}, bus.done, onehot(owner));
        n = 0;
        while (busy && n < 4*GAP_CYCLES) begin
            tickm();
            n++;
        end
        check({tag, " gap length"}, n, GAP_CYCLES);
        check({tag, " stray gnt"}, stray_gnt, 0);
        check({tag, " stray done"}, stray_done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int n;
        logic [NREQ-1:0] req_seen;
        logic [8*NREQ-1:0] cmd_seen;
        int ptr_m, owner_m, exp, str_run, link_phase, link_timer, gap_left, grants;
        bit m_idle, expect_gnt, str_armed, done_due;

        vecs[0] = '{4'b0001, 8'h01, 0};
        vecs[1] = '{4'b1111, 8'h10, 1};
        vecs[2] = '{4'b1111, 8'h20, 2};
        vecs[3] = '{4'b1010, 8'h30, 3};
        vecs[4] = '{4'b1010, 8'h40, 1};
        vecs[5] = '{4'b0001, 8'h50, 0};
        vecs[6] = '{4'b1000, 8'h60, 3};
        vecs[7] = '{4'b0110, 8'h70, 1};
        vecs[8] = '{4'b0101, 8'h80, 2};
        vecs[9] = '{4'b0011, 8'h90, 0};

        bus.cmd_in = '0;
        rst = 1'b0;
        bus.req = '0;
        bus.ready_command = 1'b1;
        clr_err = 1'b0;
        tick();
        tick();
        check("reset gnt", bus.gnt, 0);
        check("reset done", bus.done, 0);
        check("reset str", bus.str, 0);
        check("reset busy", busy, 0);
        check("reset timeout_err", timeout_err, 0);
        check("reset command", bus.command, 0);
        rst = 1'b1;

        // Arbitration table: pointer evolves from NREQ-1 through the listed grants.
        for (int v = 0; v < 10; v++) begin
            bus.req = vecs[v].req;
            set_cmds(vecs[v].base);
            wait_gnt(lat);
            check($sformatf("vec%0d gnt latency", v), lat, 1);
            check($sformatf("vec%0d gnt", v), bus.gnt, onehot(vecs[v].exp));
            check($sformatf("vec%0d command", v), bus.command, vecs[v].base + 8'(vecs[v].exp));
            bus.req = '0;
            run_link($sformatf("vec%0d", v), vecs[v].exp, (v == 0) ? 3 : 2, (v == 0) ? 100 : 10, '0);
        end

        // Fairness from reset: all requesters held high until their own grant.
        do_reset();
        bus.req = 4'b1111;
        set_cmds(8'h00);
        for (int k = 0; k < NREQ; k++) begin
            wait_gnt(lat);
            check($sformatf("fair%0d latency", k), lat, 1);
            check($sformatf("fair%0d gnt", k), bus.gnt, onehot(k));
            check($sformatf("fair%0d onehot", k), $countones(bus.gnt), 1);
            check($sformatf("fair%0d command", k), bus.command, 8'(k));
            bus.req[k] = 1'b0;
            run_link($sformatf("fair%0d", k), k, 1, 5, '0);
        end

        // Link busy while idle: no grant until ready_command returns.
        bus.ready_command = 1'b0;
        bus.req = 4'b0001;
        set_cmds(8'hA0);
        stray_gnt = 0;
        stray_done = 0;
        repeat (5) tickm();
        check("notready no gnt", stray_gnt, 0);
        check("notready idle", busy, 0);
        bus.ready_command = 1'b1;
        tick();
        check("notready gnt on ready", bus.gnt, onehot(0));
        bus.req = '0;
        run_link("notready", 0, 2, 6, '0);

        // Link never accepts: watchdog fires TIMEOUT cycles after WAIT_ACK entry.
        bus.req = 4'b0100;
        set_cmds(8'hB0);
        wait_gnt(lat);
        check("timeout gnt", bus.gnt, onehot(2));
        bus.req = '0;
        stray_gnt = 0;
        stray_done = 0;
        n = 0;
        tickm();
        while (bus.str && n < 4*STR_CYCLES) begin
            n++;
            tickm();
        end
        n = 0;
        while (!timeout_err && n < TIMEOUT + 50) begin
            tickm();
            n++;
        end
        check("timeout latency", n, TIMEOUT);
        n = 0;
        while (busy && n < 4*GAP_CYCLES) begin
            tickm();
            n++;
        end
        check("timeout gap", n, GAP_CYCLES);
        check("timeout sticky", timeout_err, 1);
        check("timeout no done", stray_done, 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_err clears", timeout_err, 0);

        // Reset during STROBE abandons the transfer.
        bus.req = 4'b0001;
        set_cmds(8'hC0);
        wait_gnt(lat);
        check("rststrobe gnt", bus.gnt, onehot(0));
        bus.req = '0;
        tick();
        check("rststrobe str up", bus.str, 1);
        rst = 1'b0;
        tick();
        check("rststrobe str", bus.str, 0);
        check("rststrobe busy", busy, 0);
        check("rststrobe command", bus.command, 0);
        rst = 1'b1;
        stray_gnt = 0;
        stray_done = 0;
        repeat (20) tickm();
        check("rststrobe no done", stray_done, 0);
        bus.req = 4'b1111;
        set_cmds(8'hD0);
        wait_gnt(lat);
        check("rststrobe first gnt", bus.gnt, onehot(0));
        check("rststrobe first command", bus.command, 8'hD0);
        bus.req = '0;
        run_link("rststrobe", 0, 1, 4, '0);

        // req[2] blips while requester 1 owns the link; pointer must stay at 1.
        bus.req = 4'b0010;
        set_cmds(8'hE0);
        wait_gnt(lat);
        check("withdraw gnt1", bus.gnt, onehot(1));
        bus.req = '0;
        run_link("withdraw", 1, 2, 8, 4'b0100);
        bus.req = 4'b1111;
        wait_gnt(lat);
        check("withdraw next gnt", bus.gnt, onehot(2));
        bus.req = '0;
        run_link("withdraw next", 2, 1, 3, '0);

        // Random traffic against a transaction-level model.
        do_reset();
        ptr_m = NREQ - 1;
        owner_m = 0;
        m_idle = 1'b1;
        str_armed = 1'b0;
        done_due = 1'b0;
        str_run = 0;
        link_phase = 0;
        link_timer = 0;
        gap_left = 0;
        grants = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req[i] && $urandom_range(0, 15) == 0) begin
                    bus.req[i] = 1'b1;
                    bus.cmd_in[8*i +: 8] = 8'($urandom);
                end else if (bus.req[i] && $urandom_range(0, 63) == 0) begin
                    bus.req[i] = 1'b0;
                end
            end
            if (link_phase == 1) begin
                if (link_timer == 0) begin
                    bus.ready_command = 1'b0;
                    link_phase = 2;
                    link_timer = $urandom_range(1, 20);
                end else link_timer--;
            end else if (link_phase == 2) begin
                if (link_timer == 0) begin
                    bus.ready_command = 1'b1;
                    link_phase = 0;
                    done_due = 1'b1;
                end else link_timer--;
            end
            req_seen = bus.req;
            cmd_seen = bus.cmd_in;
            expect_gnt = m_idle && bus.ready_command && (|req_seen);
            tick();
            if (expect_gnt) begin
                exp = rr_pick(req_seen, ptr_m);
                check("rand gnt", bus.gnt, onehot(exp));
                check("rand command", bus.command, cmd_seen[8*exp +: 8]);
                ptr_m = exp;
                owner_m = exp;
                m_idle = 1'b0;
                bus.req[exp] = 1'b0;
                str_armed = 1'b1;
                str_run = 0;
                grants++;
            end else if (bus.gnt != 0) begin
                check("rand spurious gnt", bus.gnt, 0);
            end
            if (str_armed) begin
                if (bus.str) str_run++;
                else if (str_run > 0) begin
                    check("rand str width", str_run, STR_CYCLES);
                    str_armed = 1'b0;
                    link_phase = 1;
                    link_timer = $urandom_range(0, 4);
                end
            end
            if (gap_left > 0) begin
                gap_left--;
                if (gap_left == 0) m_idle = 1'b1;
            end
            if (done_due || bus.done != 0) begin
                check("rand done", bus.done, done_due ? onehot(owner_m) : 32'(0));
                if (done_due) gap_left = GAP_CYCLES;
                done_due = 1'b0;
            end
            check("rand busy", busy, !m_idle);
        end
        check("rand grants seen", grants > 20, 1);
        check("rand no timeout", timeout_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/comm_cmd_sched.md
Name: comm_cmd_sched

Overview:
- Round-robin command scheduler in front of the Comunicaciones UART command transmitter.
- Shares the single `command`/`str`/`ready_command` link between NREQ requesters; one command is in flight at a time.
- Generates the start strobe, tracks link acceptance and completion, and enforces an inter-command gap.
- A watchdog prevents a stuck link from hanging the requesters.

Parameters:
- NREQ, 4, number of requesters (2..8).
- STR_CYCLES, 5, clock cycles `str` is held high per command (>=1).
- GAP_CYCLES, 16, idle cycles forced between commands (>=1).
- TIMEOUT, 131072, maximum cycles spent waiting for link accept plus completion.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- req  in  NREQ  per-requester request level.
- cmd_in  in  8*NREQ  requester i's command byte in bits [8i+7:8i].
- gnt  out  NREQ  one-cycle pulse: requester's command latched.
- done  out  NREQ  one-cycle pulse: requester's command completed on the link.
- busy  out  1  high whenever the FSM is not in IDLE.
- timeout_err  out  1  sticky error flag.
- clr_err  in  1  clears timeout_err.
- command  out  8  command byte to the transmitter.
- str  out  1  start strobe to the transmitter.
- ready_command  in  1  transmitter level: high = idle/finished, low = transmitting.

Behaviour:
- Reset (rst=0 at an edge):
  - State goes to IDLE; gnt, done, str, busy and timeout_err are 0; command=8'd0.
  - Round-robin pointer = NREQ-1, so requester 0 has first priority.
  - Reset mid-transfer drops str on that edge and abandons the transfer; no done is issued.
- FSM states: IDLE, STROBE, WAIT_ACK, WAIT_DONE, GAP.
- IDLE:
  - Arbitrates when ready_command=1 and |req.
  - Winner is the first asserted req searching from pointer+1 upward, with wrap-around.
  - Same edge: latch cmd_in of the winner into command, latch owner index, pointer<=owner, pulse gnt[owner], go to STROBE.
  - With ready_command=0 or no req: stay in IDLE, no gnt.
- STROBE:
  - str=1 for exactly STR_CYCLES cycles, starting the cycle after gnt.
  - Then str=0, clear the timeout counter, go to WAIT_ACK.
- WAIT_ACK: wait for ready_command=0, then go to WAIT_DONE.
- WAIT_DONE: on ready_command=1, pulse done[owner] for one cycle and go to GAP.
- Timeout counter:
  - Increments every cycle in WAIT_ACK and WAIT_DONE.
  - When it reaches TIMEOUT-1 without the exit condition: set timeout_err, go to GAP, no done.
- GAP: counts GAP_CYCLES cycles, then returns to IDLE.
- command holds the latched byte from gnt until the next grant; it is not cleared on done.
- Requester contract:
  - Hold req and cmd_in stable until gnt.
  - req still high after gnt is a new request, arbitrated only after GAP.
  - req dropping before gnt withdraws the request without side effects.
- Simultaneous requests: exactly one gnt per arbitration; the other requesters keep waiting.
- Fairness: with all req high, grant order is strictly 0,1,2,3,0,...
- timeout_err:
  - Set has priority over clr_err in the same cycle.
  - Otherwise clr_err=1 clears it next edge.
  - Does not block scheduling.
- Counter widths: clog2(STR_CYCLES+1), clog2(GAP_CYCLES+1), clog2(TIMEOUT); no overflow beyond terminal values.

Test Plan:
- Reset then single request: req=0001, cmd=8'h01; link model drops ready_command 3 cycles after str falls and raises it 100 cycles later. Required: gnt[0] one cycle after arbitration; str high exactly 5 cycles; command=8'h01; done[0] one cycle after ready_command rises; busy low 16 cycles after done.
- All four requesting with cmds 8'h00..8'h03 held high until gnt. Required: gnt order 0,1,2,3; command sequence 00,01,02,03; never two gnt bits set; each issue separated by >=16 idle cycles.
- ready_command held high after str (link never accepts). Required: timeout_err=1 exactly TIMEOUT cycles after WAIT_ACK entry; no done; FSM returns to IDLE after GAP. Then clr_err=1 clears the flag.
- Request while ready_command=0 in IDLE. Required: no gnt until ready_command=1, then gnt on that edge.
- rst=0 asserted during STROBE. Required: str=0, busy=0, command=0 at the next edge; no done. After release, requester 0 is granted first with all req high.
- req[2] raised then dropped before its turn, while requester 1 is active. Required: no gnt[2]; pointer unaffected.
